// File: rtl/unison_readout_packer.sv
// unison_readout_packer
//
// Packs the 2-bit I and Q readout streams of the dual wavelet core into
// 16-bit words and queues them in a small show-ahead FIFO.
//
// Each cycle with ud_en=1 captures the nibble {read_out_Q, read_out_I} at
// beat position k (bits [4k+3:4k]). The edge that captures beat 3 pushes
// the finished word. Any cycle with ud_en=0 discards the partial word.
//
// Ports
//   clk_master   single clock, rising edge
//   rstb         asynchronous active-low reset
//   ud_en        capture enable (already synchronous)
//   read_out_I   2-bit I-channel readout
//   read_out_Q   2-bit Q-channel readout
//   word_data    head word of the FIFO (0 while empty)
//   word_valid   FIFO non-empty
//   word_ready   consumer accepts the head word (with word_valid)
//   level        FIFO occupancy, 0..DEPTH
//   ovf          sticky overflow flag (a word was dropped)
//   ovf_clr      synchronous clear of ovf; a same-cycle overflow wins
//   word_par     XOR of the head word, 0 while empty
//                (present only when READOUT_PARITY_EN is defined)
//
// Handshake: a word leaves the FIFO on a rising edge where word_valid and
// word_ready are both high; word_data holds steady while word_valid=1 and
// word_ready=0.
//
// Build option: define READOUT_PARITY_EN to add word_par and per-entry
// parity storage.

module unison_readout_packer #(
    parameter int DEPTH = 4
) (
    input  logic        clk_master,
    input  logic        rstb,
    input  logic        ud_en,
    input  logic [1:0]  read_out_I,
    input  logic [1:0]  read_out_Q,
    output logic [15:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [4:0]  level,
    output logic        ovf,
`ifdef READOUT_PARITY_EN
    output logic        word_par,
`endif
    input  logic        ovf_clr
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    // Packing state
    logic [1:0]  beat_q, beat_d;
    logic [15:0] pack_q, pack_d;
    logic [3:0]  nibble;
    logic        push;
    logic [15:0] push_word;

    // FIFO state
    logic [15:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, pop, push_ok, ovf_set;

    always_comb begin
        nibble    = {read_out_Q, read_out_I};
        beat_d    = 2'd0;
        pack_d    = '0;
        push      = 1'b0;
        // The completed word uses the freshly captured beat-3 nibble directly,
        // so the push happens on the same edge that captures it.
        push_word = {nibble, pack_q[11:0]};
        if (ud_en) begin
            beat_d                     = beat_q + 2'd1;
            pack_d                     = pack_q;
            pack_d[{beat_q, 2'b00} +: 4] = nibble;
            if (beat_q == 2'd3) begin
                push   = 1'b1;
                pack_d = '0;
            end
        end
    end

    always_comb begin
        empty    = (count_q == 5'd0);
        full     = (count_q == DEPTH_L);
        pop      = !empty && word_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push_ok  = push && (!full || pop);
        ovf_set  = push && full && !pop;

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 5'd1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 5'd1;
        end

        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            beat_q   <= 2'd0;
            pack_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
            ovf_q    <= 1'b0;
        end else begin
            beat_q   <= beat_d;
            pack_q   <= pack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; the empty check below masks stale entries.
    always_ff @(posedge clk_master) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign word_valid = !empty;
    assign word_data  = empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign level      = count_q;
    assign ovf        = ovf_q;

`ifdef READOUT_PARITY_EN
    logic par_mem_q [DEPTH];

    always_ff @(posedge clk_master) begin
        if (push_ok) begin
            par_mem_q[wr_ptr_q] <= ^push_word;
        end
    end

    assign word_par = empty ? 1'b0 : par_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_unison_readout_packer.sv
// Bench for unison_readout_packer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.

module tb_unison_readout_packer;

    localparam int DEPTH = 4;

    logic        clk_master = 1'b0;
    logic        rstb       = 1'b0;
    logic        ud_en      = 1'b0;
    logic [1:0]  read_out_I = 2'd0;
    logic [1:0]  read_out_Q = 2'd0;
    logic [15:0] word_data;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [4:0]  level;
    logic        ovf;
    logic        ovf_clr    = 1'b0;
`ifdef READOUT_PARITY_EN
    logic        word_par;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] exp_q[$];
    logic [3:0]  nib_q[$];
    logic        exp_ovf = 1'b0;

    unison_readout_packer #(.DEPTH(DEPTH)) dut (
        .clk_master (clk_master),
        .rstb       (rstb),
        .ud_en      (ud_en),
        .read_out_I (read_out_I),
        .read_out_Q (read_out_Q),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .level      (level),
        .ovf        (ovf),
`ifdef READOUT_PARITY_EN
        .word_par   (word_par),
`endif
        .ovf_clr    (ovf_clr)
    );

    // Clock
    always #5 clk_master = ~clk_master;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_head();
        return (exp_q.size() != 0) ? exp_q[0] : 16'h0000;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        nib_q.delete();
        exp_ovf = 1'b0;
    endtask

    // One rising edge of the reference model, using the inputs held across it.
    task automatic model_edge();
        logic        do_pop;
        logic        have_word;
        logic [15:0] w;
        do_pop    = (exp_q.size() != 0) && word_ready;
        have_word = 1'b0;
        w         = 16'h0000;
        if (ud_en) begin
            nib_q.push_back({read_out_Q, read_out_I});
            if (nib_q.size() == 4) begin
                for (int k = 0; k < 4; k++) begin
                    w = w | (16'(nib_q[k]) << (4 * k));
                end
                have_word = 1'b1;
                nib_q.delete();
            end
        end else begin
            nib_q.delete();
        end
        if (ovf_clr) exp_ovf = 1'b0;
        if (have_word && exp_q.size() == DEPTH && !do_pop) exp_ovf = 1'b1;
        if (do_pop) void'(exp_q.pop_front());
        if (have_word && exp_q.size() < DEPTH) exp_q.push_back(w);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, 32'(word_valid), 32'(exp_q.size() != 0));
        check({tag, ".data"},  32'(word_data),  32'(exp_head()));
        check({tag, ".level"}, 32'(level),      32'(exp_q.size()));
        check({tag, ".ovf"},   32'(ovf),        32'(exp_ovf));
`ifdef READOUT_PARITY_EN
        check({tag, ".par"},   32'(word_par),   32'(^exp_head()));
`endif
    endtask

    // Driver: inputs change on the falling edge, outputs sampled on the next one.
    task automatic step(input logic en, input logic [3:0] nib, input logic rdy,
                        input logic clr, input string tag);
        ud_en      = en;
        read_out_I = nib[1:0];
        read_out_Q = nib[3:2];
        word_ready = rdy;
        ovf_clr    = clr;
        @(posedge clk_master);
        model_edge();
        @(negedge clk_master);
        compare_all(tag);
    endtask

    task automatic send_word(input logic [15:0] w, input logic rdy_last, input string tag);
        for (int k = 0; k < 4; k++) begin
            logic [15:0] tmp;
            tmp = w >> (4 * k);
            step(1'b1, tmp[3:0], (k == 3) ? rdy_last : 1'b0, 1'b0, tag);
        end
    endtask

    task automatic do_reset();
        rstb       = 1'b0;
        ud_en      = 1'b0;
        word_ready = 1'b0;
        ovf_clr    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_master);
        compare_all("rst_hold");
        rstb = 1'b1;
        @(negedge clk_master);
        compare_all("rst_rel");
    endtask

    initial begin
        // Basic packing: 0x1,0x2,0x3,0x4 -> 0x4321
        do_reset();
        send_word(16'h4321, 1'b0, "basic");
        check("basic_word", 32'(word_data), 32'h4321);
        check("basic_lvl",  32'(level),     32'd1);

        // Broken partial word is discarded
        do_reset();
        step(1'b1, 4'hA, 1'b0, 1'b0, "part");
        step(1'b1, 4'hB, 1'b0, 1'b0, "part");
        step(1'b0, 4'h0, 1'b0, 1'b0, "gap");
        send_word(16'h8765, 1'b0, "after_gap");
        check("gap_word", 32'(word_data), 32'h8765);
        check("gap_lvl",  32'(level),     32'd1);

        // Overflow with five words into a depth-4 FIFO, then clear
        do_reset();
        for (int n = 0; n < 5; n++) begin
            send_word(16'h1111 * 16'(n + 1), 1'b0, "fill");
        end
        check("ovf_lvl",  32'(level),     32'd4);
        check("ovf_flag", 32'(ovf),       32'd1);
        check("ovf_head", 32'(word_data), 32'h1111);
        step(1'b0, 4'h0, 1'b0, 1'b1, "ovf_clr");
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Full FIFO, push with simultaneous pop
        send_word(16'hBEEF, 1'b1, "full_pp");
        check("fpp_lvl",  32'(level),     32'd4);
        check("fpp_ovf",  32'(ovf),       32'd0);
        check("fpp_head", 32'(word_data), 32'h2222);

        // Set and clear on the same edge: set wins
        send_word(16'hCAFE, 1'b0, "setclr_a");
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 4'h5, 1'b0, 1'b1, "setclr");
        end
        check("setclr_ovf", 32'(ovf), 32'd1);

        // Drain, then push/pop together on an empty FIFO
        for (int k = 0; k < DEPTH + 1; k++) step(1'b0, 4'h0, 1'b1, 1'b1, "drain");
        check("drain_lvl", 32'(level), 32'd0);
        check("drain_data", 32'(word_data), 32'd0);
        send_word(16'h0F0F, 1'b1, "empty_pp");
        check("epp_lvl", 32'(level), 32'd1);

        // Asynchronous reset mid-word with three words queued
        do_reset();
        for (int n = 0; n < 3; n++) send_word(16'hA000 + 16'(n), 1'b0, "pre_rst");
        step(1'b1, 4'h7, 1'b0, 1'b0, "pre_rst_b");
        step(1'b1, 4'h6, 1'b0, 1'b0, "pre_rst_b");
        check("pre_rst_lvl", 32'(level), 32'd3);
        #2 rstb = 1'b0;
        model_reset();
        #1;
        check("async_valid", 32'(word_valid), 32'd0);
        check("async_lvl",   32'(level),      32'd0);
        check("async_ovf",   32'(ovf),        32'd0);
        check("async_data",  32'(word_data),  32'd0);
        ud_en = 1'b0;
        @(negedge clk_master);
        rstb = 1'b1;
        send_word(16'hCBA9, 1'b0, "post_rst");
        check("post_rst_word", 32'(word_data), 32'hCBA9);
        check("post_rst_lvl",  32'(level),     32'd1);

`ifdef READOUT_PARITY_EN
        do_reset();
        send_word(16'h0001, 1'b0, "par1");
        send_word(16'h0003, 1'b0, "par3");
        check("par_first", 32'(word_par), 32'd1);
        step(1'b0, 4'h0, 1'b1, 1'b0, "par_pop");
        check("par_second", 32'(word_par), 32'd0);
`endif

        // Random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic en, rdy, clr;
            en  = ($urandom_range(0, 99) < 88);
            rdy = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 5);
            step(en, 4'($urandom_range(0, 15)), rdy, clr, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
